// File: rtl/filt_sched.sv
// filt_sched: round-robin scheduler sharing one FILTA/FILTB averaging datapath across NCH channels.
// Build option FILT_SCHED_FILTB_EN adds the per-channel DML file and FILTB path; otherwise dmlp is 0.

module filt_sched #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req,
    input  logic [3*NCH-1:0] fi_bus,
    input  logic             clr,
    output logic [NCH-1:0]   ack,
    output logic             out_valid,
    output logic [CW-1:0]    out_ch,
    output logic [11:0]      dmsp,
    output logic [13:0]      dmlp,
    output logic             busy
);

    // state | meaning
    // IDLE  | wait for clr or a request; arbitrate and latch channel/FI on grant
    // RD    | fetch DMS/DML of the granted channel into operand registers
    // UPD   | compute, write back, present result and pulse ack
    typedef enum logic [1:0] {IDLE, RD, UPD} state_t;

    state_t          state;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   ch;
    logic [2:0]      fi_q;
    logic [11:0]     op_dms;
    logic [11:0]     dms_mem [NCH];
    logic [2:0]      fi_arr  [NCH];

    logic            gnt_found;
    logic [CW-1:0]   gnt_idx;
    logic [7:0]      a_hi;
    logic [11:0]     dmsp_c;

    for (genvar k = 0; k < NCH; k++) begin : g_fi
        assign fi_arr[k] = fi_bus[3*k +: 3];
    end

    // Scan from farthest to nearest so the first requester after ptr wins.
    always_comb begin : arb
        logic [CW:0] s;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        s         = '0;
        for (int i = NCH; i >= 1; i--) begin
            s = {1'b0, ptr} + (CW+1)'(i);
            if (s >= (CW+1)'(NCH))
                s = s - (CW+1)'(NCH);
            if (req[s[CW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = s[CW-1:0];
            end
        end
    end

    // DIF>>5 computed directly: the low five bits of FI<<9 are zero, so they only
    // contribute a borrow when DMS has any low bits set. DIFS is the top bit and
    // the +3840 adjustment is a sign extension to 12 bits.
    assign a_hi   = {1'b0, fi_q, 4'd0} - {1'b0, op_dms[11:5]} - {7'd0, |op_dms[4:0]};
    assign dmsp_c = {{4{a_hi[7]}}, a_hi} + op_dms;

`ifdef FILT_SCHED_FILTB_EN
    logic [13:0] op_dml;
    logic [13:0] dml_mem [NCH];
    logic [7:0]  b_hi;
    logic [13:0] dmlp_c;

    assign b_hi   = {1'b0, fi_q, 4'd0} - {1'b0, op_dml[13:7]} - {7'd0, |op_dml[6:0]};
    assign dmlp_c = {{6{b_hi[7]}}, b_hi} + op_dml;
`else
    assign dmlp = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= CW'(NCH-1);
            ch        <= '0;
            fi_q      <= '0;
            op_dms    <= '0;
            ack       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            dmsp      <= '0;
            busy      <= 1'b0;
            for (int k = 0; k < NCH; k++) dms_mem[k] <= '0;
`ifdef FILT_SCHED_FILTB_EN
            op_dml    <= '0;
            dmlp      <= '0;
            for (int k = 0; k < NCH; k++) dml_mem[k] <= '0;
`endif
        end else begin
            ack       <= '0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        for (int k = 0; k < NCH; k++) dms_mem[k] <= '0;
`ifdef FILT_SCHED_FILTB_EN
                        for (int k = 0; k < NCH; k++) dml_mem[k] <= '0;
`endif
                    end else if (gnt_found) begin
                        ch    <= gnt_idx;
                        fi_q  <= fi_arr[gnt_idx];
                        ptr   <= gnt_idx;
                        busy  <= 1'b1;
                        state <= RD;
                    end
                end
                RD: begin
                    op_dms <= dms_mem[ch];
`ifdef FILT_SCHED_FILTB_EN
                    op_dml <= dml_mem[ch];
`endif
                    state  <= UPD;
                end
                UPD: begin
                    dms_mem[ch] <= dmsp_c;
                    dmsp        <= dmsp_c;
`ifdef FILT_SCHED_FILTB_EN
                    dml_mem[ch] <= dmlp_c;
                    dmlp        <= dmlp_c;
`endif
                    out_ch      <= ch;
                    ack         <= NCH'(1) << ch;
                    out_valid   <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filt_sched.sv
// Scoreboard bench for filt_sched: stimulus pushes expected results, a monitor pops on out_valid.

module tb_filt_sched;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic             clk;
    logic             rst_n;
    logic [NCH-1:0]   req;
    logic [3*NCH-1:0] fi_bus;
    logic             clr;
    logic [NCH-1:0]   ack;
    logic             out_valid;
    logic [CW-1:0]    out_ch;
    logic [11:0]      dmsp;
    logic [13:0]      dmlp;
    logic             busy;

    typedef struct {
        int ch;
        int s;
        int l;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    filt_sched #(.NCH(NCH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .fi_bus    (fi_bus),
        .clr       (clr),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .dmsp      (dmsp),
        .dmlp      (dmlp),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int exp_l(input int v);
`ifdef FILT_SCHED_FILTB_EN
        return v;
`else
        return (v == 0) ? 0 : 0;
`endif
    endfunction

    task automatic push(input int c, input int s, input int l);
        exp_t e;
        e.ch = c;
        e.s  = s;
        e.l  = exp_l(l);
        exp_q.push_back(e);
    endtask

    task automatic set_fi(input int k, input logic [2:0] v);
        fi_bus[3*k +: 3] = v;
    endtask

    // Monitor: every out_valid must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_ch", int'(out_ch), e.ch);
                    chk("dmsp", int'(dmsp), e.s);
                    chk("dmlp", int'(dmlp), e.l);
                    chk("ack_onehot", int'(ack), 1 << e.ch);
                end
            end else begin
                chk("ack_without_valid", int'(ack), 0);
            end
        end
    end

    // Wait for ack[k], check latency and busy, then drop req[k] before the next edge.
    task automatic serve(input int k, input int lat);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (ack[k]) seen = 1'b1;
            else if (n < lat) chk($sformatf("busy_wait_ch%0d", k), int'(busy), 1);
        end
        chk($sformatf("ack_seen_ch%0d", k), int'(seen), 1);
        chk($sformatf("latency_ch%0d", k), n, lat);
        chk($sformatf("busy_at_ack_ch%0d", k), int'(busy), 0);
        req[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_ch"}, int'(out_ch), 0);
        chk({tag, "_dmsp"}, int'(dmsp), 0);
        chk({tag, "_dmlp"}, int'(dmlp), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = '0;
        clr      = 1'b0;
        fi_bus   = '0;
        #1;
        check_zero_outputs("reset");
        do_reset();

        // Single ch0 update from cleared state, then FI=0 from DMS=DML=112.
        set_fi(0, 3'd7);
        req = 4'b0001;
        push(0, 112, 112);
        serve(0, 3);
        @(negedge clk);
        chk("ack_pulse_width", int'(ack), 0);
        chk("dmsp_hold", int'(dmsp), 112);
        set_fi(0, 3'd0);
        req = 4'b0001;
        push(0, 108, 111);
        serve(0, 3);
        @(negedge clk);

        // All four requesting from reset: served 0,1,2,3 three cycles apart.
        do_reset();
        for (int k = 0; k < NCH; k++) set_fi(k, 3'd7);
        req = 4'b1111;
        for (int k = 0; k < NCH; k++) push(k, 112, 112);
        for (int k = 0; k < NCH; k++) serve(k, 3);
        @(negedge clk);
        chk("rr_all_done", int'(req), 0);

        // Pointer wrap: after ch2, ch0 beats ch2.
        do_reset();
        set_fi(2, 3'd7);
        req = 4'b0100;
        push(2, 112, 112);
        serve(2, 3);
        set_fi(0, 3'd7);
        set_fi(2, 3'd0);
        req = 4'b0101;
        push(0, 112, 112);
        push(2, 108, 111);
        serve(0, 3);
        serve(2, 3);
        @(negedge clk);

        // Load ch1, then clr with req pending: clr wins, state cleared.
        set_fi(1, 3'd7);
        req = 4'b0010;
        push(1, 112, 112);
        serve(1, 3);
        @(negedge clk);
        req = 4'b0010;
        clr = 1'b1;
        @(negedge clk);
        chk("clr_no_grant_busy", int'(busy), 0);
        clr = 1'b0;
        push(1, 112, 112);
        serve(1, 3);
        @(negedge clk);

        // Reset during RD aborts the update and clears ch0 state.
        set_fi(0, 3'd0);
        req = 4'b0001;
        @(negedge clk);
        chk("rd_busy", int'(busy), 1);
        rst_n = 1'b0;
        req   = '0;
        #1;
        check_zero_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_fi(0, 3'd7);
        req = 4'b0001;
        push(0, 112, 112);
        serve(0, 3);
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/filt_sched.md
Name: filt_sched

Overview:
- Time-shares one FILTA/FILTB short/long-term averaging datapath across NCH ADPCM channels of the multi-channel codec.
- Holds per-channel DMS (12b) and DML (14b) state in an internal register file.
- Arbitrates update requests round-robin, sequences read/compute/write-back, and returns updated DMSP/DMLP with a per-channel ack.

Parameters:
NCH, 4, number of channels (2..16)
CW, 2, channel index width (log2 of NCH rounded up, at least 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NCH  per-channel update request (level, held until ack)
fi_bus  input  3*NCH  FI per channel; channel k at bits [3k+2:3k]
clr  input  1  synchronous clear of all channel state
ack  output  NCH  one-cycle grant-complete pulse to the served channel
out_valid  output  1  one-cycle strobe, coincident with ack
out_ch  output  CW  channel index of current result
dmsp  output  12  updated DMS of out_ch
dmlp  output  14  updated DML of out_ch
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE. All DMS/DML entries are 0. Round-robin pointer is NCH-1, so channel 0 has first priority. ack, out_valid, out_ch, dmsp, dmlp and busy are all 0. A reset mid-operation aborts the operation with no ack and no write-back.
- FSM states: IDLE, RD, UPD.
- IDLE:
  - clr has priority. All entries clear to 0 in one cycle, no grant, stay in IDLE.
  - Otherwise, if req is nonzero: grant the first requesting channel after the pointer (wrapping), latch its index and FI from fi_bus, update the pointer to that index, go to RD.
- RD: read DMS[ch] and DML[ch] into operand registers, go to UPD.
- UPD:
  - Compute DMSP/DMLP, write both back to entry ch, register dmsp/dmlp/out_ch, pulse ack[ch] and out_valid, go to IDLE.
  - Latency is 3 cycles from the IDLE sampling edge to the ack cycle. Throughput is one update per 3 cycles.
- clr asserted outside IDLE is ignored. Requesters must hold it until busy is low.
- req is sampled only in IDLE. fi_bus for the granted channel is sampled only at grant, so later changes do not affect the in-flight update.
- A requester sees ack and drops req on the same edge. If req is still high in the following IDLE cycle, it counts as a new request and takes its normal round-robin turn.
- dmsp, dmlp and out_ch hold their last values between updates.
- FILTA arithmetic, all unsigned with masking:
  - DIF = ((FI<<9) + 8192 - DMS) & 8191
  - DIFS = DIF[12]
  - DIFSX = DIFS ? (DIF>>5)+3840 : DIF>>5
  - DMSP = (DIFSX + DMS) & 4095
- FILTB arithmetic:
  - DIF = ((FI<<11) + 32768 - DML) & 32767
  - DIFS = DIF[14]
  - DIFSX = DIFS ? (DIF>>7)+16128 : DIF>>7
  - DMLP = (DIFSX + DML) & 16383
- Simultaneous requests are resolved by round-robin only. There is no starvation: each requester waits at most NCH-1 grants.

Optional Feature:
- Macro: FILT_SCHED_FILTB_EN.
- Defined: the DML register file and FILTB path are present, and dmlp behaves as above.
- Undefined: no DML storage or FILTB logic is built. dmlp is tied to 0. The FSM and all other outputs are unchanged.

Test Plan:
- Reset, then req=4'b0001 with ch0 FI=3'b111 -> ack[0] on the 3rd cycle after the sampling edge; dmsp=112, dmlp=112, out_ch=0.
- Repeat ch0 with FI=0 (DMS=112, DML=112) -> dmsp=108, dmlp=111.
- req=4'b1111 held from reset, each requester dropping req after its ack -> ack order ch0, ch1, ch2, ch3, spaced 3 cycles apart; busy low only between grants.
- After ch2 is served, req=4'b0101 -> ch0 is served before ch2 (pointer wrap).
- Load ch1 to nonzero, then pulse clr in IDLE -> next ch1 update with FI=7 returns dmsp=112, dmlp=112.
- Assert rst_n low during RD -> no ack; all outputs 0; ch0 update with FI=7 returns 112/112.
